out_port_alloc: RTL
===================

Name: out_port_alloc

Overview:
- Per-output-port allocation stage directly downstream of the round-robin matrix arbiter in the switch.
- Feeds masked requests to the arbiter, latches the arbiter's binary grant, and holds the output port for the winner until its tail flit passes (wormhole lock).
- Drives crossbar select/valid and the one-hot pop strobe back to the input buffers.
- One instance per output port.

Parameters:
- IN_N, 5, number of input ports competing for this output; matches the arbiter's IN_N.
- WDT_CYCLES, 64, watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset. Asynchronous, active-high.
- req_i, input, IN_N, per-input request for this output. Asserted only while a head flit sits at the buffer front.
- flit_vld_i, input, IN_N, per-input front-of-buffer flit valid.
- flit_tail_i, input, IN_N, per-input front flit is a tail flit. Head==tail is legal for single-flit packets.
- out_rdy_i, input, 1, downstream accepts a flit this cycle.
- arb_req_o, output, IN_N, masked requests to the arbiter's req_i.
- grant_i, input, $clog2(IN_N), arbiter binary grant.
- grant_vld_i, input, 1, arbiter grant valid.
- xbar_sel_o, output, $clog2(IN_N), crossbar mux select.
- xbar_vld_o, output, 1, output flit valid.
- in_rd_o, output, IN_N, one-hot pop strobe to the selected input buffer.
- locked_o, output, 1, port is held by a packet.
- wdt_err_o, output, 1, sticky watchdog error. Present only with the macro.

Behaviour:
- FSM has two states, IDLE and LOCKED. Registers: state_q, sel_q.
- Reset (async, rst_i=1) forces IDLE and sel_q=0. All outputs are 0 and wdt_err_o is cleared. Reset mid-packet abandons the packet with no flush.
- IDLE:
  - arb_req_o = req_i & flit_vld_i.
  - xbar_vld_o=0, in_rd_o=0.
  - On grant_vld_i=1: sel_q<=grant_i, next state LOCKED.
- LOCKED:
  - arb_req_o = 0. This is mandatory: the arbiter rotates priority on any grant, so it must see no requests while the port is held.
  - xbar_sel_o = sel_q.
  - xbar_vld_o = flit_vld_i[sel_q].
  - xfer = flit_vld_i[sel_q] & out_rdy_i.
  - in_rd_o = xfer ? onehot(sel_q) : 0.
  - xfer & flit_tail_i[sel_q] returns the FSM to IDLE.
  - If the selected input bubbles (flit_vld_i[sel_q]=0), the port stays LOCKED with xbar_vld_o=0.
- Latency: grant at cycle t, first flit presented at t+1. After the tail transfer at cycle t, IDLE arbitration runs at t+1, giving one bubble between packets.
- xbar_sel_o = sel_q in every state. locked_o = (state_q==LOCKED).
- grant_vld_i in LOCKED is illegal and ignored; the bench flags it with an assertion.
- grant_i >= IN_N is illegal and is masked to no lock.
- in_rd_o, xbar_vld_o and arb_req_o are combinational from state and inputs, with no extra register stage.

Optional Feature:
- Macro OUT_PORT_WATCHDOG_EN.
- When defined:
  - A counter of width $clog2(WDT_CYCLES+1) counts consecutive LOCKED cycles without xfer. It is cleared on xfer and in IDLE.
  - When the count reaches WDT_CYCLES, the FSM is forced to IDLE and wdt_err_o is set sticky until reset.
- When undefined:
  - No counter and no wdt_err_o port.
  - The lock holds indefinitely.

Decomposition:
- Shared package noc_pkg holds:
  - the FSM state localparams (ST_IDLE=1'b0, ST_LOCKED=1'b1);
  - the default port count;
  - the flit field offsets consumed by the crossbar.
- Sub-module out_port_wdt holds the watchdog counter and sticky flag. It is instantiated only under OUT_PORT_WATCHDOG_EN.
- The matrix arbiter is instantiated alongside this block at the switch level, not inside it.

Test Plan (all with IN_N=5):
- Single-flit packet: req_i=5'b00100, flit_vld_i[2]=1, flit_tail_i[2]=1, grant_i=2 at t → t+1: xbar_sel_o=2, xbar_vld_o=1, in_rd_o=5'b00100; t+2: locked_o=0, arb_req_o=5'b00100 if still requesting.
- 4-flit packet on input 1 with req_i[3] also high → arb_req_o=0 for all 4 LOCKED cycles; exactly 4 pops on in_rd_o[1]; in_rd_o[3] never asserted until input 1's tail has passed.
- Backpressure: out_rdy_i=0 for 3 cycles mid-packet → xbar_vld_o=1, in_rd_o=0, locked_o=1 throughout; the transfer resumes on the first out_rdy_i=1.
- Source bubble: flit_vld_i[sel]=0 for 2 cycles → xbar_vld_o=0, still LOCKED, no pops.
- Reset asserted mid-packet (after flit 2 of 4) → immediately locked_o=0, in_rd_o=0, xbar_sel_o=0; after release, arbitration resumes normally.
- Watchdog (macro defined, WDT_CYCLES=8): lock with flit_vld_i[sel]=0 for 8 cycles → wdt_err_o=1 and locked_o=0 on cycle 9; wdt_err_o stays 1 until rst_i.

Source files
------------

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared switch definitions:
//     - output-port allocator FSM state encodings
//     - default number of input ports per output
//     - flit field offsets used by the crossbar datapath
//   No ports; imported by the allocator and its watchdog.
// ---------------------------------------------------------------------------
package noc_pkg;

    // Allocator FSM states
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    // Default radix: inputs competing for one output port
    localparam int NOC_IN_N = 5;

    // Flit layout as seen by the crossbar: {tail, head, data}
    localparam int FLIT_DATA_LSB = 0;
    localparam int FLIT_DATA_W   = 32;
    localparam int FLIT_HEAD_BIT = FLIT_DATA_LSB + FLIT_DATA_W;
    localparam int FLIT_TAIL_BIT = FLIT_HEAD_BIT + 1;
    localparam int FLIT_W        = FLIT_TAIL_BIT + 1;

endpackage

// File: rtl/out_port_wdt.sv
// ---------------------------------------------------------------------------
// out_port_wdt
//   Lock watchdog for one output port. Counts consecutive locked cycles
//   with no flit transfer; on reaching WDT_CYCLES it pulses expire_o (which
//   the allocator uses to drop the lock) and sets a sticky error flag.
//   Ports:
//     clk_i, rst_i   clock, async active-high reset
//     locked_i       port currently held by a packet
//     xfer_i         a flit moved through the port this cycle
//     expire_o       combinational: this cycle is the last allowed stall
//     err_o          sticky error, cleared only by reset
// ---------------------------------------------------------------------------
module out_port_wdt
    import noc_pkg::*;
#(
    parameter int WDT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic locked_i,
    input  logic xfer_i,
    output logic expire_o,
    output logic err_o
);

    localparam int CNT_W = $clog2(WDT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // The stalled cycle that would bring the count to WDT_CYCLES is the one
    // that releases the lock, so the port is idle on the following cycle.
    assign expire_o = locked_i && !xfer_i && (cnt_q == CNT_W'(WDT_CYCLES - 1));
    assign err_o    = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!locked_i || xfer_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (expire_o) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/out_port_alloc.sv
// ---------------------------------------------------------------------------
// out_port_alloc
//   Per-output-port allocation stage behind the round-robin matrix arbiter.
//   Masks requests into the arbiter, latches its binary grant, and holds the
//   port for the winner until the tail flit transfers (wormhole lock).
//   Optional lock watchdog: compile with OUT_PORT_WATCHDOG_EN.
//   Ports:
//     clk_i, rst_i        clock, async active-high reset
//     req_i               per-input request (head flit at buffer front)
//     flit_vld_i          per-input front flit valid
//     flit_tail_i         per-input front flit is a tail
//     out_rdy_i           downstream accepts a flit
//     arb_req_o           masked requests to the arbiter
//     grant_i/grant_vld_i arbiter binary grant
//     xbar_sel_o          crossbar select (held owner)
//     xbar_vld_o          output flit valid
//     in_rd_o             one-hot pop strobe to the owning input buffer
//     locked_o            port held by a packet
//     wdt_err_o           sticky watchdog error (watchdog builds only)
// ---------------------------------------------------------------------------
module out_port_alloc
    import noc_pkg::*;
#(
    parameter  int IN_N       = NOC_IN_N,
    parameter  int WDT_CYCLES = 64,
    localparam int SEL_W      = $clog2(IN_N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_N-1:0]  req_i,
    input  logic [IN_N-1:0]  flit_vld_i,
    input  logic [IN_N-1:0]  flit_tail_i,
    input  logic             out_rdy_i,
    output logic [IN_N-1:0]  arb_req_o,
    input  logic [SEL_W-1:0] grant_i,
    input  logic             grant_vld_i,
    output logic [SEL_W-1:0] xbar_sel_o,
    output logic             xbar_vld_o,
    output logic [IN_N-1:0]  in_rd_o,
    output logic             locked_o
`ifdef OUT_PORT_WATCHDOG_EN
    ,
    output logic             wdt_err_o
`endif
);

    // Elaboration guards: a one-input port has no select, and a zero
    // watchdog limit would never let a packet through.
    if (IN_N < 2) begin : g_bad_in_n
        $error("out_port_alloc: IN_N must be at least 2");
    end
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("out_port_alloc: WDT_CYCLES must be positive");
    end

    logic             state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             grant_ok;
    logic             xfer;
    logic             wdt_expire;

    // Out-of-range grants cannot select a real input, so they never lock.
    assign grant_ok = grant_vld_i && ({1'b0, grant_i} < (SEL_W + 1)'(IN_N));
    assign xfer     = (state_q == ST_LOCKED) && flit_vld_i[sel_q] && out_rdy_i;

    assign xbar_sel_o = sel_q;
    assign locked_o   = (state_q == ST_LOCKED);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        arb_req_o  = '0;
        xbar_vld_o = 1'b0;
        in_rd_o    = '0;
        case (state_q)
            ST_IDLE: begin
                // Gated by reset so every output reads zero while held.
                arb_req_o = rst_i ? '0 : (req_i & flit_vld_i);
                if (grant_ok) begin
                    sel_d   = grant_i;
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                // Requests stay masked here: the arbiter rotates priority on
                // every grant, so it must not see competition while held.
                xbar_vld_o = flit_vld_i[sel_q];
                if (xfer) begin
                    in_rd_o = IN_N'(1) << sel_q;
                end
                if ((xfer && flit_tail_i[sel_q]) || wdt_expire) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef OUT_PORT_WATCHDOG_EN
    out_port_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .locked_i (state_q == ST_LOCKED),
        .xfer_i   (xfer),
        .expire_o (wdt_expire),
        .err_o    (wdt_err_o)
    );
`else
    assign wdt_expire = 1'b0;
`endif

endmodule
